frs_message_queue: RTL and testbench
====================================

// Module: frs_message_queue
// PURPOSE
//  FRS (Function Readiness Status) message queue for the FRS Queueing extended capability.
//  Buffers incoming FRS messages in a FIFO and presents the oldest entry as the FRS Message Queue register.
//  Maintains the RW1C FRS Queueing Status bits.
//  Raises an interrupt request gated by frs_interrupt_enable, which comes from the FRS Queueing Control register.
// PARAMETERS
//  QUEUE_DEPTH  8  number of message entries; any value >= 1; also driven on max_depth
// PORTS
//  clk                   in   1   clock
//  rst_n                 in   1   async active-low reset
//  msg_valid             in   1   FRS message arrival strobe, one message per cycle, no backpressure
//  msg_func_id           in   16  Function ID of arriving message
//  msg_reason            in   4   FRS reason code of arriving message
//  queue_deq             in   1   software write to FRS Message Queue register: dequeue head (data ignored)
//  queue_rd_data         out  32  {12'b0, reason, func_id} of head entry; 32'h0 when empty
//  status_wr_en          in   1   software write strobe to FRS Queueing Status register
//  status_wr_data        in   16  status write data; bit0/bit1 are RW1C
//  status_rd_data        out  16  {14'b0, msg_overflow, msg_received}
//  max_depth             out  12  constant QUEUE_DEPTH
//  frs_interrupt_enable  in   1   from FRS Queueing Control register
//  frs_int_req           out  1   one-cycle interrupt request pulse
//  occupancy             out  $clog2(QUEUE_DEPTH+1)  entries held (only with FRS_OCCUPANCY_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): head/tail pointers=0, count=0, status bits=0, frs_int_req=0, queue_rd_data=0.
//  Enqueue:
//   - accept = msg_valid && (count<QUEUE_DEPTH || (queue_deq && count!=0)).
//   - Accepted entry is written at tail; tail advances; visible at queue_rd_data next cycle if queue was empty.
//  Dequeue:
//   - queue_deq && count!=0: head advances next cycle.
//   - queue_deq on empty: ignored, no state change.
//  Simultaneous enqueue+dequeue: count unchanged. A full queue accepts the new message and does not overflow.
//  Pointers wrap from QUEUE_DEPTH-1 to 0 (modulo, no power-of-2 requirement).
//  msg_received (bit0): set the cycle after any accepted message.
//  msg_overflow (bit1): set the cycle after msg_valid is dropped. A dropped message leaves the queue contents untouched.
//  RW1C: status_wr_en with a 1 in bit n clears bit n. Set has priority over clear in the same cycle. Writes to other bits have no effect.
//  frs_int_req: single-cycle registered pulse, asserted the cycle after either event below (while frs_interrupt_enable=1):
//   - msg_received goes 0->1 while frs_interrupt_enable=1.
//   - frs_interrupt_enable goes 0->1 while msg_received=1.
//   No further pulses while msg_received stays 1 and the enable stays 1.
//  Reset mid-operation: queue contents are discarded; all outputs return to reset values immediately (async).
//  queue_rd_data and status_rd_data are combinational from registered state, with zero read latency.
// CONFIGURATION
//  FRS_OCCUPANCY_EN defined:
//   - occupancy port exists and is driven by the registered count, range 0..QUEUE_DEPTH, updated the cycle after enq/deq.
//  FRS_OCCUPANCY_EN undefined:
//   - occupancy port is absent; all other behaviour is identical.
// TESTING
//  Reset, then read: queue_rd_data=0, status_rd_data=0, max_depth=8, frs_int_req=0.
//  Enable=1, msg_valid with func_id=16'h0102, reason=4'h3:
//   - next cycle queue_rd_data=32'h0003_0102 and status bit0=1.
//   - frs_int_req is one pulse.
//   - a second message produces no second pulse.
//  Fill 8 entries, then a 9th msg_valid:
//   - bit1=1; head is still entry 0.
//   - 8 dequeues return entries 0..7 in order, then 32'h0.
//  Full queue with msg_valid and queue_deq in the same cycle:
//   - bit1 stays 0 and count stays 8.
//   - the new entry appears after 7 further dequeues.
//  status_wr_data=16'h0001 in the same cycle as an accepted message: bit0 remains 1. The next write of 16'h0003 clears both bits.
//  Enable=0, receive a message (no pulse), then set enable=1: frs_int_req pulses once the next cycle.
//  Assert rst_n=0 mid-fill: queue becomes empty and the status bits clear.

Source files
------------

// File: rtl/frs_message_queue.sv
// FRS message queue: FIFO of {reason, func_id} entries, RW1C status bits and interrupt pulse.
// Optional occupancy output enabled by defining FRS_OCCUPANCY_EN.
module frs_message_queue #(
   parameter int unsigned QUEUE_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        msg_valid,
   input  logic [15:0] msg_func_id,
   input  logic [3:0]  msg_reason,
   input  logic        queue_deq,
   output logic [31:0] queue_rd_data,
   input  logic        status_wr_en,
   input  logic [15:0] status_wr_data,
   output logic [15:0] status_rd_data,
   output logic [11:0] max_depth,
   input  logic        frs_interrupt_enable,
   output logic        frs_int_req
`ifdef FRS_OCCUPANCY_EN
   ,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
`endif
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
   localparam logic [PTR_W-1:0] LAST_C = PTR_W'(QUEUE_DEPTH - 1);

   logic [19:0]      mem [QUEUE_DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             received_q, received_d;
   logic             overflow_q, overflow_d;
   logic             int_level_q, int_level;
   logic             int_req_q;
   logic             deq, accept, drop;

   assign deq    = queue_deq && (count_q != '0);
   // A full queue can still take a message when a dequeue frees a slot this cycle.
   assign accept = msg_valid && ((count_q < DEPTH_C) || deq);
   assign drop   = msg_valid && !accept;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (deq) begin
         head_d = (head_q == LAST_C) ? '0 : head_q + 1'b1;
      end
      if (accept) begin
         tail_d = (tail_q == LAST_C) ? '0 : tail_q + 1'b1;
      end
      case ({accept, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Set wins over a same-cycle RW1C clear.
   always_comb begin
      received_d = received_q;
      overflow_d = overflow_q;
      if (status_wr_en && status_wr_data[0]) received_d = 1'b0;
      if (status_wr_en && status_wr_data[1]) overflow_d = 1'b0;
      if (accept) received_d = 1'b1;
      if (drop)   overflow_d = 1'b1;
   end

   // Pulse on the rising edge of (enable && msg_received), covering both trigger orders.
   assign int_level = frs_interrupt_enable && received_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         received_q  <= 1'b0;
         overflow_q  <= 1'b0;
         int_level_q <= 1'b0;
         int_req_q   <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         received_q  <= received_d;
         overflow_q  <= overflow_d;
         int_level_q <= int_level;
         int_req_q   <= int_level && !int_level_q;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[tail_q] <= {msg_reason, msg_func_id};
      end
   end

   assign queue_rd_data  = (count_q != '0) ? {12'b0, mem[head_q]} : 32'h0;
   assign status_rd_data = {14'b0, overflow_q, received_q};
   assign max_depth      = 12'(QUEUE_DEPTH);
   assign frs_int_req    = int_req_q;

`ifdef FRS_OCCUPANCY_EN
   assign occupancy = count_q;
`endif

endmodule

// File: tb/tb_frs_message_queue.sv
// Scoreboard bench for frs_message_queue: expected dequeue data is queued by the stimulus
// and checked by an independent monitor; status and interrupt checks are directed.
module tb_frs_message_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        msg_valid;
   logic [15:0] msg_func_id;
   logic [3:0]  msg_reason;
   logic        queue_deq;
   logic [31:0] queue_rd_data;
   logic        status_wr_en;
   logic [15:0] status_wr_data;
   logic [15:0] status_rd_data;
   logic [11:0] max_depth;
   logic        frs_interrupt_enable;
   logic        frs_int_req;
`ifdef FRS_OCCUPANCY_EN
   logic [3:0]  occupancy;
`endif

   int checks = 0;
   int errors = 0;
   int int_cnt = 0;
   int snap;
   logic [31:0] exp_q[$];

   frs_message_queue #(.QUEUE_DEPTH(8)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .msg_valid            (msg_valid),
      .msg_func_id          (msg_func_id),
      .msg_reason           (msg_reason),
      .queue_deq            (queue_deq),
      .queue_rd_data        (queue_rd_data),
      .status_wr_en         (status_wr_en),
      .status_wr_data       (status_wr_data),
      .status_rd_data       (status_rd_data),
      .max_depth            (max_depth),
      .frs_interrupt_enable (frs_interrupt_enable),
      .frs_int_req          (frs_int_req)
`ifdef FRS_OCCUPANCY_EN
      ,
      .occupancy            (occupancy)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every dequeue strobe presents the head, compared against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && queue_deq) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_unexpected: got %h expected no dequeue", queue_rd_data);
         end else begin
            check("deq_data", queue_rd_data, exp_q.pop_front());
         end
      end
      if (frs_int_req) int_cnt++;
   end

   // One clock with the given inputs held across the rising edge, then back to idle.
   task automatic cyc(input logic mv, input logic [15:0] fid, input logic [3:0] rsn,
                      input logic dq, input logic swe, input logic [15:0] swd);
      msg_valid      = mv;
      msg_func_id    = fid;
      msg_reason     = rsn;
      queue_deq      = dq;
      status_wr_en   = swe;
      status_wr_data = swd;
      @(posedge clk);
      #1;
      msg_valid      = 1'b0;
      msg_func_id    = 16'h0;
      msg_reason     = 4'h0;
      queue_deq      = 1'b0;
      status_wr_en   = 1'b0;
      status_wr_data = 16'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic enq(input logic [15:0] fid, input logic [3:0] rsn);
      cyc(1'b1, fid, rsn, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic deq_exp(input logic [31:0] exp);
      exp_q.push_back(exp);
      cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h0);
   endtask

   task automatic clr_status();
      cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 16'h0003);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      msg_valid = 1'b0; msg_func_id = 16'h0; msg_reason = 4'h0; queue_deq = 1'b0;
      status_wr_en = 1'b0; status_wr_data = 16'h0; frs_interrupt_enable = 1'b0;
      #23;
      check("reset_rd_data", queue_rd_data, 32'h0);
      check("reset_status", {16'h0, status_rd_data}, 32'h0);
      check("max_depth", {20'h0, max_depth}, 32'd8);
      check("reset_int_req", {31'h0, frs_int_req}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First message with interrupts enabled
      frs_interrupt_enable = 1'b1;
      snap = int_cnt;
      enq(16'h0102, 4'h3);
      check("first_rd_data", queue_rd_data, 32'h0003_0102);
      check("first_status", {16'h0, status_rd_data}, 32'h1);
      idle(2);
      check("first_pulse_count", int_cnt - snap, 1);
      enq(16'h0203, 4'h4);
      idle(3);
      check("second_msg_no_pulse", int_cnt - snap, 1);
      deq_exp(32'h0003_0102);
      deq_exp(32'h0004_0203);
      check("drained_rd_data", queue_rd_data, 32'h0);
      deq_exp(32'h0);
      clr_status();
      check("status_cleared", {16'h0, status_rd_data}, 32'h0);

      // Fill, then overflow
      for (int i = 0; i < 8; i++) enq(16'h1000 + 16'(i), 4'(i));
      check("full_no_overflow", {16'h0, status_rd_data}, 32'h1);
      enq(16'hDEAD, 4'hD);
      check("overflow_status", {16'h0, status_rd_data}, 32'h3);
      check("overflow_head", queue_rd_data, 32'h0000_1000);
`ifdef FRS_OCCUPANCY_EN
      check("occupancy_full", {28'h0, occupancy}, 32'd8);
`endif
      for (int i = 0; i < 8; i++) deq_exp({12'h0, 4'(i), 16'h1000 + 16'(i)});
      deq_exp(32'h0);
      clr_status();

      // Full queue with simultaneous enqueue and dequeue
      for (int i = 0; i < 8; i++) enq(16'h2000 + 16'(i), 4'h1);
      exp_q.push_back(32'h0001_2000);
      cyc(1'b1, 16'h2FFF, 4'hF, 1'b1, 1'b0, 16'h0);
      check("simul_no_overflow", {16'h0, status_rd_data}, 32'h1);
      check("simul_head", queue_rd_data, 32'h0001_2001);
      for (int i = 1; i < 8; i++) deq_exp(32'h0001_2000 + 32'(i));
      deq_exp(32'h000F_2FFF);
      deq_exp(32'h0);
      clr_status();

      // Set beats a same-cycle clear
      cyc(1'b1, 16'h3000, 4'h2, 1'b0, 1'b1, 16'h0001);
      check("set_over_clear", {16'h0, status_rd_data}, 32'h1);
      clr_status();
      check("clear_both", {16'h0, status_rd_data}, 32'h0);
      deq_exp(32'h0002_3000);

      // Message while disabled, then enable
      frs_interrupt_enable = 1'b0;
      idle(2);
      snap = int_cnt;
      enq(16'h4000, 4'h5);
      idle(3);
      check("disabled_no_pulse", int_cnt - snap, 0);
      frs_interrupt_enable = 1'b1;
      @(posedge clk); #1;
      check("enable_pulse", {31'h0, frs_int_req}, 32'h1);
      idle(1);
      check("enable_pulse_ends", {31'h0, frs_int_req}, 32'h0);
      idle(2);
      check("enable_single_pulse", int_cnt - snap, 1);

      // Asynchronous reset mid-fill
      enq(16'h5000, 4'h6);
      enq(16'h5001, 4'h6);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_rd_data", queue_rd_data, 32'h0);
      check("async_rst_status", {16'h0, status_rd_data}, 32'h0);
      check("async_rst_int_req", {31'h0, frs_int_req}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      check("post_rst_rd_data", queue_rd_data, 32'h0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
